seven_segment_capture: RTL and testbench

SEVEN_SEGMENT_CAPTURE -- requirements
Module: seven_segment_capture

---
 rtl/seven_segment_capture.sv | 167 ++++++++++++++++
 tb/tb_seven_segment_capture.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_capture.sv
// Captures one 4-digit frame from a multiplexed, active-low seven-segment display bus.
// Each digit must stay stable for STABLE_CYCLES samples before it is decoded into its nibble slot.
module seven_segment_capture #(
    parameter int STABLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  segment,
    input  logic [3:0]  digit_sel,
    input  logic        capture,
    output logic [15:0] value,
    output logic        valid,
    output logic        error,
    output logic        busy,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] prev_q, prev_d;
    logic [3:0]  run_q, run_d;
    logic [15:0] tmo_q, tmo_d;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] store_q, store_d;
    logic        sticky_q, sticky_d;
    logic [15:0] value_q, value_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;

    logic        onehot;
    logic        accept;
    logic        timeout_hit;
    logic [4:0]  dec;

    // Returns {recognised, nibble}; unknown patterns (blank included) decode as not recognised.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h40:   decode = {1'b1, 4'h0};
            7'h79:   decode = {1'b1, 4'h1};
            7'h24:   decode = {1'b1, 4'h2};
            7'h30:   decode = {1'b1, 4'h3};
            7'h19:   decode = {1'b1, 4'h4};
            7'h12:   decode = {1'b1, 4'h5};
            7'h02:   decode = {1'b1, 4'h6};
            7'h78:   decode = {1'b1, 4'h7};
            7'h00:   decode = {1'b1, 4'h8};
            7'h10:   decode = {1'b1, 4'h9};
            7'h08:   decode = {1'b1, 4'hA};
            7'h03:   decode = {1'b1, 4'hB};
            7'h46:   decode = {1'b1, 4'hC};
            7'h21:   decode = {1'b1, 4'hD};
            7'h06:   decode = {1'b1, 4'hE};
            7'h0E:   decode = {1'b1, 4'hF};
            default: decode = 5'b0_0000;
        endcase
    endfunction

    // run_d counts the current sample too, so a value seen for N cycles has run_d == N.
    always_comb begin
        prev_d = {digit_sel, segment};
        run_d  = 4'd1;
        if ({digit_sel, segment} == prev_q) begin
            run_d = (run_q == 4'd15) ? run_q : run_q + 4'd1;
        end
    end

    always_comb begin
        onehot      = (digit_sel != 4'd0) && ((digit_sel & (digit_sel - 4'd1)) == 4'd0);
        accept      = (state_q == SCAN) && onehot && (run_d >= 4'(STABLE_CYCLES));
        timeout_hit = (tmo_q == 16'(TIMEOUT_CYCLES - 1));
        dec         = decode(segment);
    end

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        seen_d   = seen_q;
        store_d  = store_q;
        sticky_d = sticky_q;
        value_d  = value_q;
        error_d  = error_q;
        valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d  = SCAN;
                    tmo_d    = 16'd0;
                    seen_d   = 4'd0;
                    store_d  = 16'd0;
                    sticky_d = 1'b0;
                end
            end
            SCAN: begin
                tmo_d = tmo_q + 16'd1;
                if (accept) begin
                    for (int i = 0; i < 4; i++) begin
                        if (digit_sel[i]) begin
                            store_d[4*i +: 4] = dec[4] ? dec[3:0] : 4'h0;
                            seen_d[i]         = 1'b1;
                        end
                    end
                    if (!dec[4]) begin
                        sticky_d = 1'b1;
                    end
                end
                // A frame that completes on the timeout cycle still counts as complete.
                if (seen_q == 4'hF) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    value_d = store_d;
                    error_d = sticky_d;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    value_d = store_d;
                    error_d = sticky_d | (seen_d != 4'hF);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            prev_q   <= 11'd0;
            run_q    <= 4'd0;
            tmo_q    <= 16'd0;
            seen_q   <= 4'd0;
            store_q  <= 16'd0;
            sticky_q <= 1'b0;
            value_q  <= 16'd0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            run_q    <= run_d;
            tmo_q    <= tmo_d;
            seen_q   <= seen_d;
            store_q  <= store_d;
            sticky_q <= sticky_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    assign value       = value_q;
    assign valid       = valid_q;
    assign error       = error_q;
    assign busy        = (state_q == SCAN);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture: a frame table plus hand-written reset and
// capture-while-busy sequences, checked through an expected-frame queue.
module tb_seven_segment_capture;

    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  segment;
    logic [3:0]  digit_sel;
    logic        capture;
    logic [15:0] value;
    logic        valid;
    logic        error;
    logic        busy;
    logic [1:0]  dbg_state_o;

    seven_segment_capture #(
        .STABLE_CYCLES  (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .segment     (segment),
        .digit_sel   (digit_sel),
        .capture     (capture),
        .value       (value),
        .valid       (valid),
        .error       (error),
        .busy        (busy),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0][6:0] seg;
        int              hold;
        int              mh;
        logic [15:0]     exp_value;
        logic            exp_err;
        int              exp_busy;
    } vec_t;

    // {scan cycles[7:0], error, value[15:0]}
    logic [24:0] exp_q[$];
    vec_t        vecs[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_valid = 0;
    int          busy_cnt = 0;
    logic        prev_busy = 1'b0;
    logic        prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                                input logic [6:0] s3, input int hold, input int mh,
                                input logic [15:0] ev, input logic ee, input int eb);
        vec_t v;
        v.seg[0]    = s0;
        v.seg[1]    = s1;
        v.seg[2]    = s2;
        v.seg[3]    = s3;
        v.hold      = hold;
        v.mh        = mh;
        v.exp_value = ev;
        v.exp_err   = ee;
        v.exp_busy  = eb;
        return v;
    endfunction

    // Scoreboard: every valid pulse must match the oldest expected frame.
    always @(negedge clock) begin
        if (reset) begin
            busy_cnt   = 0;
            prev_busy  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (valid) begin
                logic [24:0] got;
                n_valid++;
                check("valid_after_scan", {30'd0, prev_busy, busy}, 32'd2);
                check("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
                check("valid_in_done", {30'd0, dbg_state_o}, 32'd2);
                check("valid_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    got = exp_q.pop_front();
                    check("frame_value", {16'd0, value}, {16'd0, got[15:0]});
                    check("frame_error", {31'd0, error}, {31'd0, got[16]});
                    check("scan_cycles", busy_cnt, {24'd0, got[24:17]});
                end
                busy_cnt = 0;
            end
            if (busy) busy_cnt++;
            prev_busy  = busy;
            prev_valid = valid;
        end
    end

    task automatic idle_inputs();
        digit_sel = 4'd0;
        segment   = 7'h7F;
    endtask

    task automatic pulse_capture();
        @(posedge clock); #1;
        capture = 1'b1;
        @(posedge clock); #1;
        capture = 1'b0;
    endtask

    task automatic drive_digit(input int i, input logic [6:0] seg, input int hold);
        digit_sel = 4'b0001 << i;
        segment   = seg;
        repeat (hold) @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input int start);
        int c;
        c = 0;
        while (n_valid == start && c < 40) begin
            @(negedge clock); #1;
            c++;
        end
        check("valid_within_budget", {31'd0, n_valid != start}, 32'd1);
    endtask

    task automatic run_frame(input vec_t v);
        int start;
        exp_q.push_back({8'(v.exp_busy), v.exp_err, v.exp_value});
        start = n_valid;
        pulse_capture();
        for (int i = 0; i < 4; i++) begin
            if (i == 2 && v.mh > 0) begin
                digit_sel = 4'b0011;
                segment   = 7'h00;
                repeat (v.mh) @(posedge clock);
                #1;
            end
            drive_digit(i, v.seg[i], v.hold);
        end
        idle_inputs();
        wait_valid(start);
        repeat (2) @(negedge clock);
        check("value_hold", {16'd0, value}, {16'd0, v.exp_value});
        check("error_hold", {31'd0, error}, {31'd0, v.exp_err});
        check("busy_low_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        vecs.push_back(mk(7'h19, 7'h30, 7'h24, 7'h79, 2, 0, 16'h1234, 1'b0, 9));
        vecs.push_back(mk(7'h19, 7'h30, 7'h7F, 7'h79, 2, 0, 16'h1034, 1'b1, 9));
        vecs.push_back(mk(7'h0E, 7'h06, 7'h21, 7'h46, 2, 3, 16'hCDEF, 1'b0, 12));
        vecs.push_back(mk(7'h40, 7'h79, 7'h24, 7'h30, 2, 0, 16'h3210, 1'b0, 9));
        vecs.push_back(mk(7'h19, 7'h12, 7'h02, 7'h78, 2, 0, 16'h7654, 1'b0, 9));
        vecs.push_back(mk(7'h00, 7'h10, 7'h08, 7'h03, 2, 0, 16'hBA98, 1'b0, 9));
        vecs.push_back(mk(7'h46, 7'h21, 7'h06, 7'h0E, 2, 0, 16'hFEDC, 1'b0, 9));
        vecs.push_back(mk(7'h19, 7'h30, 7'h24, 7'h79, 1, 0, 16'h0000, 1'b1, 16));
        vecs.push_back(mk(7'h19, 7'h30, 7'h24, 7'h79, 3, 0, 16'h1234, 1'b0, 12));
        vecs.push_back(mk(7'h7E, 7'h30, 7'h24, 7'h79, 2, 0, 16'h1230, 1'b1, 9));

        // Reset held together with capture must leave the block idle.
        reset   = 1'b1;
        capture = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clock);
        #1;
        reset   = 1'b0;
        capture = 1'b0;
        @(negedge clock);
        check("reset_value", {16'd0, value}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_error", {31'd0, error}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_state", {30'd0, dbg_state_o}, 32'd0);

        for (int k = 0; k < vecs.size(); k++) begin
            run_frame(vecs[k]);
        end

        // Reset in the middle of a scan abandons the frame and clears value.
        start = n_valid;
        pulse_capture();
        drive_digit(0, 7'h19, 2);
        drive_digit(1, 7'h30, 2);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        idle_inputs();
        @(negedge clock);
        check("midscan_reset_value", {16'd0, value}, 32'd0);
        check("midscan_reset_error", {31'd0, error}, 32'd0);
        check("midscan_reset_busy", {31'd0, busy}, 32'd0);
        repeat (25) @(negedge clock);
        check("midscan_reset_no_valid", n_valid, start);
        run_frame(vecs[0]);

        // Capture pulses during SCAN and during DONE must not start another frame.
        exp_q.push_back({8'd9, 1'b0, 16'h1234});
        start = n_valid;
        pulse_capture();
        drive_digit(0, 7'h19, 2);
        drive_digit(1, 7'h30, 2);
        digit_sel = 4'b0100;
        segment   = 7'h24;
        @(posedge clock); #1;
        capture = 1'b1;
        @(posedge clock); #1;
        capture = 1'b0;
        drive_digit(3, 7'h79, 2);
        idle_inputs();
        @(posedge clock); #1;
        capture = 1'b1;
        @(posedge clock); #1;
        capture = 1'b0;
        wait_valid(start);
        repeat (25) @(negedge clock);
        check("single_valid_per_capture", n_valid, start + 1);
        check("busy_idle_at_end", {31'd0, busy}, 32'd0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
